// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data-RAM arbiter (mem_arbiter).
// Read-response owner encoding plus a helper that classifies a granted access.
package mem_arb_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_MAX_CPU_RUN = 4;
  localparam int RUN_CNT_W       = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  // Only reads produce a response, so a granted write leaves no owner behind.
  function automatic owner_t read_owner(input logic cpu_gnt, input logic cpu_we,
                                        input logic ext_gnt, input logic ext_we);
    owner_t owner;
    owner = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      owner = OWN_CPU;
    end else if (ext_gnt && !ext_we) begin
      owner = OWN_EXT;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating run-length counter with synchronous clear, used to bound how long
// the external port can be held off by back-to-back CPU grants.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = RUN_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};

  // Clear wins over increment so an external grant always restarts the run.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-cycle arbiter sharing one synchronous single-port data RAM between the
// CPU data port and an external loader/debug port. Fairness counter: MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_CPU_RUN = DEF_MAX_CPU_RUN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_t            resp_owner;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              ext_turn;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(MAX_CPU_RUN);

  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 run_inc;
  logic                 run_clr;

  // The run only counts CPU wins that actually kept a waiting external port out.
  assign run_inc = cpu_gnt & ext_req;
  assign run_clr = ext_gnt | ~ext_req;

  arb_starve_cnt #(
    .W(RUN_CNT_W)
  ) u_starve_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (run_inc),
    .clr  (run_clr),
    .count(run_cnt)
  );

  assign ext_turn = ext_req & (~cpu_req | (run_cnt == RUN_LIMIT));
`else
  assign ext_turn = ext_req & ~cpu_req;
`endif

  // Grants are forced low during reset so nothing reaches the RAM.
  assign ext_gnt   = ~reset & ext_turn;
  assign cpu_gnt   = ~reset & cpu_req & ~ext_turn;
  assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;

  always_comb begin
    mem_en    = cpu_gnt | ext_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= read_owner(cpu_gnt, cpu_we, ext_gnt, ext_we);
    end
  end

  // Each port keeps the last data it was handed while the other port reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (resp_owner == OWN_CPU) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (resp_owner == OWN_EXT) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid = (resp_owner == OWN_CPU);
  assign ext_rvalid = (resp_owner == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid ? mem_rdata : ext_rdata_q;

endmodule
